// File: rtl/adsr_envelope.sv
// ADSR envelope generator applying a programmable gain to a signed sample stream.
// Latency: sample_out and gain are registered, 1 cycle after sample_valid / control inputs.
// Backpressure: none; every sample_valid produces sample_out_valid exactly one cycle later.
module adsr_envelope #(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       note_on,
  input  logic                       note_off,
  input  logic                       beat,
  input  logic        [GAIN_W-1:0]   attack_step,
  input  logic        [GAIN_W-1:0]   decay_step,
  input  logic        [GAIN_W-1:0]   sustain_level,
  input  logic        [GAIN_W-1:0]   release_step,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic        [GAIN_W-1:0]   gain,
  output logic        [2:0]          env_state,
  output logic                       active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [GAIN_W-1:0] GMAX = '1;
  localparam int PW = SAMPLE_W + GAIN_W + 1;

  state_t            state, state_nxt;
  logic [GAIN_W-1:0] gain_nxt;

  // Attack sum carries one extra bit so a large step saturates instead of wrapping.
  logic [GAIN_W:0] attack_sum;
  // gain - decay_step <= sustain_level is tested as gain <= sustain_level + decay_step
  // so the subtraction never has to go negative.
  logic [GAIN_W:0] decay_floor;

  assign attack_sum  = {1'b0, gain} + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  // Next-state and next-gain: note events first, otherwise the per-state beat step.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    if (note_on) begin
      // Retrigger keeps the current gain so the attack ramps from where it is.
      state_nxt = ATTACK;
    end else if (note_off && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nxt = RELEASE;
    end else begin
      case (state)
        IDLE: begin
          gain_nxt = '0;
        end
        ATTACK: begin
          if (attack_step == '0) begin
            gain_nxt  = GMAX;
            state_nxt = DECAY;
          end else if (beat) begin
            if (attack_sum >= {1'b0, GMAX}) begin
              gain_nxt  = GMAX;
              state_nxt = DECAY;
            end else begin
              gain_nxt = attack_sum[GAIN_W-1:0];
            end
          end
        end
        DECAY: begin
          if (decay_step == '0 || gain <= sustain_level) begin
            gain_nxt  = sustain_level;
            state_nxt = SUSTAIN;
          end else if (beat) begin
            if ({1'b0, gain} <= decay_floor) begin
              gain_nxt  = sustain_level;
              state_nxt = SUSTAIN;
            end else begin
              gain_nxt = gain - decay_step;
            end
          end
        end
        SUSTAIN: begin
          gain_nxt = sustain_level;
        end
        RELEASE: begin
          if (release_step == '0 || (beat && gain <= release_step)) begin
            gain_nxt  = '0;
            state_nxt = IDLE;
          end else if (beat) begin
            gain_nxt = gain - release_step;
          end
        end
        default: begin
          gain_nxt  = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Envelope state and gain registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gain  <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
    end
  end

  assign env_state = state;
  assign active    = (state != IDLE);

  // Full-width signed product; the gain is zero-extended so it is never negative.
  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic                 unused_prod_bits;

  assign sample_ext = PW'(sample_in);
  assign gain_ext   = PW'({1'b0, gain});
  assign product    = sample_ext * gain_ext;
  // Dropping the low GAIN_W bits of a two's complement product is a floor divide.
  assign unused_prod_bits = ^{product[PW-1], product[GAIN_W-1:0]};

  // Sample datapath: scale on sample_valid, unity bypass at full gain, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= sample_valid;
      if (sample_valid) begin
        if (gain == GMAX) begin
          sample_out <= sample_in;
        end else begin
          sample_out <= product[GAIN_W +: SAMPLE_W];
        end
      end
    end
  end

endmodule
